c2_arbiter_mc: RTL and testbench
================================

# c2_arbiter_mc

Parametrised multi-client Command & Control arbiter. It owns the single UART, decodes host command bytes through a parameter table, and ACK-echoes accepted commands. It grants exclusive UART and control access to one of NUM_CLIENTS sub-modules (loader, debugger, future units), then enforces a soft-reset cleanup. Compared with the two-client C2 arbiter it adds a NACK reply for unknown commands, a BUSY watchdog with timeout report, and a configurable cleanup length.

## Interface
- NUM_CLIENTS, 2: number of grantable sub-modules (1..8); CIDX_W = max(1, $clog2(NUM_CLIENTS)).
- NUM_CMDS, 4: number of command-table entries (1..16).
- CMD_CODES, {8'hDE,8'hCE,8'h1D,8'h1C}: packed NUM_CMDS×8 command bytes; entry i sits at bits [8i+7:8i].
- CMD_CLIENT, {1,1,0,0}: packed NUM_CMDS×CIDX_W target client per entry.
- CMD_MODE, 4'b0110: packed NUM_CMDS mode bit per entry (entry i = bit i). 1C→0 IMEM, 1D→1 DMEM, CE→1 continuous, DE→0 step.
- TIMEOUT_CYCLES, 0: BUSY watchdog limit; 0 disables.
- CLEANUP_CYCLES, 2: soft-reset assertion length (≥1).
- NACK_BYTE, 8'h15; TIMEOUT_BYTE, 8'hEE: report bytes.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset; one clock, synchronous, active-high
- uart_rx_data_i  in  8  received byte
- uart_rx_ready_i  in  1  one-cycle byte-valid strobe
- uart_tx_data_o  out  8  TX byte (muxed)
- uart_tx_start_o  out  1  TX start pulse (muxed)
- uart_tx_done_i  in  1  TX complete strobe
- soft_reset_o  out  1  global flush
- grant_o  out  NUM_CLIENTS  one-hot grant
- mode_o  out  1  mode bit of latched command
- done_i  in  NUM_CLIENTS  per-client done
- client_tx_data_i  in  NUM_CLIENTS×8  per-client TX byte
- client_tx_start_i  in  NUM_CLIENTS  per-client TX start
- active_client_o  out  CIDX_W  latched client index
- timeout_o  out  1  one-cycle pulse on watchdog expiry
- c2_waiting_o  out  1  high in IDLE, ACK_TX, ACK_WAIT

## Operation
- States: IDLE, ACK_TX, ACK_WAIT, BUSY, CLEANUP, REPORT_TX, REPORT_WAIT.
- IDLE + rx_ready: latch byte. Table hit (lowest index wins) → latch client and mode → ACK_TX. Miss → REPORT_TX with NACK_BYTE; no cleanup.
- ACK_TX: tx_data = latched byte, tx_start = 1 for exactly one cycle → ACK_WAIT.
- ACK_WAIT: stay until uart_tx_done_i → BUSY.
- BUSY: grant_o[client] = 1; TX mux selects that client's data/start. done_i[client] → CLEANUP. done_i of other clients is ignored.
- Watchdog: cycle counter cleared on BUSY entry. If TIMEOUT_CYCLES ≠ 0 and the counter reaches TIMEOUT_CYCLES−1 without done: pulse timeout_o, set timeout flag, → CLEANUP. Same-cycle done and expiry: done wins, no timeout.
- CLEANUP: soft_reset_o = 1 for CLEANUP_CYCLES cycles, grants 0. Then timeout flag set → REPORT_TX with TIMEOUT_BYTE; otherwise → IDLE.
- REPORT_TX: one-cycle tx_start with report byte → REPORT_WAIT; uart_tx_done_i → IDLE, flag cleared.
- rx_ready outside IDLE is dropped. uart_tx_done_i outside the WAIT states is ignored.
- Outside ACK_TX, REPORT_TX and BUSY: tx_data = 0, tx_start = 0.

## Timing
- Reset values: state IDLE; grant_o 0, soft_reset_o 0, uart_tx_start_o 0, uart_tx_data_o 0, mode_o 0, active_client_o 0, timeout_o 0; c2_waiting_o 1; counters and flags 0.
- Reset asserted mid-operation: next edge forces IDLE and all outputs above. No ACK, NACK or report is emitted.
- Command byte at edge N → tx_start high in cycle N+1.
- Grant rises the cycle after tx_done is seen. Grant falls the cycle after done_i is seen; soft_reset rises in that same cycle.
- Grant and soft_reset are never high together.
- Counter width $clog2(TIMEOUT_CYCLES+1); no wrap (saturates at expiry).
- Back-to-back commands: the first IDLE cycle after return accepts a new byte.

## Structure
- Package c2_pkg: state_t enum, default command constants (1C/1D/CE/DE), NACK_BYTE and TIMEOUT_BYTE defaults.
- Sub-module c2_cmd_decoder: combinational table lookup, byte → {hit, client, mode}, lowest-index priority.
- Watchdog counter and TX mux stay inline.

## Test plan
- 8'h1C, tx_done, done_i[0] → echo 1C; grant_o = 01; mode_o = 0; soft_reset for 2 cycles; back to IDLE.
- 8'hDE, tx_done, client-1 TX pulses during BUSY → echo DE; grant_o = 10; mode_o = 0; client-1 bytes pass to the UART; done_i[0] ignored.
- 8'h42 → tx byte 8'h15; no grant; no soft_reset; IDLE after tx_done.
- TIMEOUT_CYCLES = 16, 8'hCE, no done → timeout_o pulses 16 cycles after BUSY entry; soft_reset; then TIMEOUT_BYTE EE sent.
- Same config, done_i[1] in the expiry cycle → no timeout_o; normal cleanup.
- rst_i during BUSY → next cycle grant_o = 0, soft_reset_o = 0, IDLE; a subsequent 1D is accepted normally.

Source files
------------

// File: rtl/c2_pkg.sv
// Shared types and defaults for the multi-client C2 arbiter.
// Holds the FSM state encoding, default command bytes and report bytes.
package c2_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StAckTx,
    StAckWait,
    StBusy,
    StCleanup,
    StReportTx,
    StReportWait
  } state_t;

  localparam logic [7:0] CmdImem = 8'h1C;
  localparam logic [7:0] CmdDmem = 8'h1D;
  localparam logic [7:0] CmdCont = 8'hCE;
  localparam logic [7:0] CmdStep = 8'hDE;

  localparam logic [31:0] DefaultCmdCodes = {CmdStep, CmdCont, CmdDmem, CmdImem};

  localparam logic [7:0] NackByteDefault    = 8'h15;
  localparam logic [7:0] TimeoutByteDefault = 8'hEE;

  // Client index width; a single client still needs one bit.
  function automatic int unsigned cidx_w(input int unsigned n);
    int unsigned w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/c2_arbiter_mc_if.sv
// UART byte interface between the C2 arbiter and the UART core.
// master = arbiter side, slave = UART side.
interface c2_arbiter_mc_if;

  logic [7:0] rx_data;
  logic       rx_ready;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_done;

  modport master (
    input  rx_data,
    input  rx_ready,
    input  tx_done,
    output tx_data,
    output tx_start
  );

  modport slave (
    output rx_data,
    output rx_ready,
    output tx_done,
    input  tx_data,
    input  tx_start
  );

endinterface

// File: rtl/c2_cmd_decoder.sv
// Combinational command-table lookup: byte -> {hit, client, mode}.
// When several entries carry the same byte, the lowest index wins.
module c2_cmd_decoder #(
  parameter int unsigned                   NUM_CMDS   = 4,
  parameter int unsigned                   CIDX_W     = 1,
  parameter logic [NUM_CMDS*8-1:0]         CMD_CODES  = 32'hDECE1D1C,
  parameter logic [NUM_CMDS*CIDX_W-1:0]    CMD_CLIENT = 4'b1100,
  parameter logic [NUM_CMDS-1:0]           CMD_MODE   = 4'b0110
) (
  input  logic [7:0]        byte_i,
  output logic              hit_o,
  output logic [CIDX_W-1:0] client_o,
  output logic              mode_o
);

  always_comb begin
    hit_o    = 1'b0;
    client_o = '0;
    mode_o   = 1'b0;
    // Walk downwards so a lower-index match overwrites a higher one.
    for (int i = int'(NUM_CMDS) - 1; i >= 0; i--) begin
      if (CMD_CODES[8*i +: 8] == byte_i) begin
        hit_o    = 1'b1;
        client_o = CMD_CLIENT[CIDX_W*i +: CIDX_W];
        mode_o   = CMD_MODE[i];
      end
    end
  end

endmodule

// File: rtl/c2_arbiter_mc.sv
// Multi-client C2 arbiter: decodes host commands, ACK/NACK-echoes them, grants one client
// exclusive UART access, watches for a BUSY timeout and runs a soft-reset cleanup.
module c2_arbiter_mc
  import c2_pkg::*;
#(
  parameter int unsigned                NUM_CLIENTS    = 2,
  parameter int unsigned                NUM_CMDS       = 4,
  localparam int unsigned               CIDX_W         = cidx_w(NUM_CLIENTS),
  parameter logic [NUM_CMDS*8-1:0]      CMD_CODES      = DefaultCmdCodes,
  parameter logic [NUM_CMDS*CIDX_W-1:0] CMD_CLIENT     = 4'b1100,
  parameter logic [NUM_CMDS-1:0]        CMD_MODE       = 4'b0110,
  parameter int unsigned                TIMEOUT_CYCLES = 0,
  parameter int unsigned                CLEANUP_CYCLES = 2,
  parameter logic [7:0]                 NACK_BYTE      = NackByteDefault,
  parameter logic [7:0]                 TIMEOUT_BYTE   = TimeoutByteDefault
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  c2_arbiter_mc_if.master          uart_io,
  output logic                     soft_reset_o,
  output logic [NUM_CLIENTS-1:0]   grant_o,
  output logic                     mode_o,
  input  logic [NUM_CLIENTS-1:0]   done_i,
  input  logic [NUM_CLIENTS*8-1:0] client_tx_data_i,
  input  logic [NUM_CLIENTS-1:0]   client_tx_start_i,
  output logic [CIDX_W-1:0]        active_client_o,
  output logic                     timeout_o,
  output logic                     c2_waiting_o
);

  localparam bit          TimeoutEn = (TIMEOUT_CYCLES != 0);
  localparam int unsigned WdogW     = TimeoutEn ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int unsigned CleanW    = (CLEANUP_CYCLES > 1) ? $clog2(CLEANUP_CYCLES) : 1;
  localparam logic [WdogW-1:0]  WdogLast  = WdogW'(TIMEOUT_CYCLES - 1);
  localparam logic [CleanW-1:0] CleanLast = CleanW'(CLEANUP_CYCLES - 1);

  state_t                   state_d, state_q;
  logic [NUM_CLIENTS-1:0]   grant_d, grant_q;
  logic                     soft_reset_d, soft_reset_q;
  logic                     tx_start_d, tx_start_q;
  logic [7:0]               tx_data_d, tx_data_q;
  logic                     mode_d, mode_q;
  logic [CIDX_W-1:0]        client_d, client_q;
  logic                     timeout_d, timeout_q;
  logic                     tmo_flag_d, tmo_flag_q;
  logic                     waiting_d, waiting_q;
  logic [WdogW-1:0]         wdog_d, wdog_q;
  logic [CleanW-1:0]        clean_d, clean_q;

  logic                     dec_hit;
  logic [CIDX_W-1:0]        dec_client;
  logic                     dec_mode;

  c2_cmd_decoder #(
    .NUM_CMDS   (NUM_CMDS),
    .CIDX_W     (CIDX_W),
    .CMD_CODES  (CMD_CODES),
    .CMD_CLIENT (CMD_CLIENT),
    .CMD_MODE   (CMD_MODE)
  ) u_decoder (
    .byte_i   (uart_io.rx_data),
    .hit_o    (dec_hit),
    .client_o (dec_client),
    .mode_o   (dec_mode)
  );

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    soft_reset_d = soft_reset_q;
    tx_start_d   = 1'b0;
    tx_data_d    = tx_data_q;
    mode_d       = mode_q;
    client_d     = client_q;
    timeout_d    = 1'b0;
    tmo_flag_d   = tmo_flag_q;
    waiting_d    = waiting_q;
    wdog_d       = wdog_q;
    clean_d      = clean_q;

    unique case (state_q)
      StIdle: begin
        if (uart_io.rx_ready) begin
          tx_start_d = 1'b1;
          if (dec_hit) begin
            state_d   = StAckTx;
            client_d  = dec_client;
            mode_d    = dec_mode;
            tx_data_d = uart_io.rx_data;
          end else begin
            state_d   = StReportTx;
            tx_data_d = NACK_BYTE;
            waiting_d = 1'b0;
          end
        end
      end

      StAckTx: begin
        state_d   = StAckWait;
        tx_data_d = '0;
      end

      StAckWait: begin
        if (uart_io.tx_done) begin
          state_d   = StBusy;
          waiting_d = 1'b0;
          wdog_d    = '0;
          for (int c = 0; c < int'(NUM_CLIENTS); c++) begin
            grant_d[c] = (client_q == CIDX_W'(c));
          end
        end
      end

      StBusy: begin
        // Client done takes priority over a watchdog expiry in the same cycle.
        if (done_i[client_q]) begin
          state_d      = StCleanup;
          grant_d      = '0;
          soft_reset_d = 1'b1;
          clean_d      = '0;
        end else if (TimeoutEn && (wdog_q == WdogLast)) begin
          state_d      = StCleanup;
          grant_d      = '0;
          soft_reset_d = 1'b1;
          clean_d      = '0;
          timeout_d    = 1'b1;
          tmo_flag_d   = 1'b1;
        end else if (TimeoutEn) begin
          wdog_d = wdog_q + 1'b1;
        end
      end

      StCleanup: begin
        if (clean_q == CleanLast) begin
          soft_reset_d = 1'b0;
          if (tmo_flag_q) begin
            state_d    = StReportTx;
            tx_start_d = 1'b1;
            tx_data_d  = TIMEOUT_BYTE;
          end else begin
            state_d   = StIdle;
            waiting_d = 1'b1;
          end
        end else begin
          clean_d = clean_q + 1'b1;
        end
      end

      StReportTx: begin
        state_d   = StReportWait;
        tx_data_d = '0;
      end

      StReportWait: begin
        if (uart_io.tx_done) begin
          state_d    = StIdle;
          tmo_flag_d = 1'b0;
          waiting_d  = 1'b1;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      grant_q      <= '0;
      soft_reset_q <= 1'b0;
      tx_start_q   <= 1'b0;
      tx_data_q    <= '0;
      mode_q       <= 1'b0;
      client_q     <= '0;
      timeout_q    <= 1'b0;
      tmo_flag_q   <= 1'b0;
      waiting_q    <= 1'b1;
      wdog_q       <= '0;
      clean_q      <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      soft_reset_q <= soft_reset_d;
      tx_start_q   <= tx_start_d;
      tx_data_q    <= tx_data_d;
      mode_q       <= mode_d;
      client_q     <= client_d;
      timeout_q    <= timeout_d;
      tmo_flag_q   <= tmo_flag_d;
      waiting_q    <= waiting_d;
      wdog_q       <= wdog_d;
      clean_q      <= clean_d;
    end
  end

  // While a client owns the UART its TX strobe and byte pass straight through.
  always_comb begin
    uart_io.tx_data  = tx_data_q;
    uart_io.tx_start = tx_start_q;
    if (state_q == StBusy) begin
      uart_io.tx_data  = client_tx_data_i[{client_q, 3'b000} +: 8];
      uart_io.tx_start = client_tx_start_i[client_q];
    end
  end

  assign soft_reset_o    = soft_reset_q;
  assign grant_o         = grant_q;
  assign mode_o          = mode_q;
  assign active_client_o = client_q;
  assign timeout_o       = timeout_q;
  assign c2_waiting_o    = waiting_q;

endmodule

// File: tb/tb_c2_arbiter_mc.sv
// Self-checking bench for c2_arbiter_mc: a transaction-level timeline model predicts every
// output each cycle; directed scenarios additionally pin observed values to literals.
module tb_c2_arbiter_mc;

  localparam int TMO  = 16;
  localparam int CLN  = 2;
  localparam logic [7:0] NACK = 8'h15;
  localparam logic [7:0] TBYTE = 8'hEE;

  logic        clk = 1'b0;
  logic        rst;
  logic        soft_reset, mode, timeout, waiting, active;
  logic [1:0]  grant, done, cl_start;
  logic [15:0] cl_data;

  always #5 clk = ~clk;

  c2_arbiter_mc_if uart_if ();

  c2_arbiter_mc #(
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .uart_io           (uart_if),
    .soft_reset_o      (soft_reset),
    .grant_o           (grant),
    .mode_o            (mode),
    .done_i            (done),
    .client_tx_data_i  (cl_data),
    .client_tx_start_i (cl_start),
    .active_client_o   (active),
    .timeout_o         (timeout),
    .c2_waiting_o      (waiting)
  );

  // Command table as the host sees it.
  logic [7:0] tbl_code   [4] = '{8'h1C, 8'h1D, 8'hCE, 8'hDE};
  int         tbl_client [4] = '{0, 0, 1, 1};
  bit         tbl_mode   [4] = '{1'b0, 1'b1, 1'b1, 1'b0};

  int n_chk = 0;
  int n_fail = 0;
  bit chk_on = 1'b0;

  // Expected outputs for the current cycle.
  logic [1:0] e_grant;
  logic       e_sr, e_txs, e_mode, e_tmo, e_wait, e_busy;
  logic [7:0] e_txd;
  int         e_client;
  logic [7:0] xd;
  logic       xs;

  // Observation monitor state.
  int         g_run, last_g_len, sr_run, last_sr_len, n_tmo, tmo_dist, n_arb;
  logic [1:0] seen_grant;
  bit         saw_sr;
  logic [7:0] last_arb;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic int lookup(input logic [7:0] b);
    for (int i = 0; i < 4; i++) if (tbl_code[i] == b) return i;
    return -1;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    e_grant = '0; e_sr = 0; e_txs = 0; e_txd = '0; e_tmo = 0; e_wait = 1; e_busy = 0;
  endtask

  task automatic set_reset_exp();
    set_idle();
    e_mode = 0;
    e_client = 0;
  endtask

  // Random traffic on inputs the current state must ignore.
  task automatic noise();
    uart_if.rx_ready = ($urandom_range(0, 3) == 0);
    uart_if.rx_data  = 8'($urandom);
    uart_if.tx_done  = ($urandom_range(0, 3) == 0);
    done     = 2'($urandom);
    cl_data  = 16'($urandom);
    cl_start = 2'($urandom);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      noise();
      uart_if.rx_ready = 1'b0;
      step();
    end
  endtask

  task automatic clr_mon();
    seen_grant = '0; saw_sr = 0; n_tmo = 0; tmo_dist = 0; n_arb = 0; last_arb = '0;
    last_g_len = 0; last_sr_len = 0;
  endtask

  task automatic wait_tx_done(input int dly);
    for (int i = 0; i < dly; i++) begin
      noise();
      uart_if.tx_done = 1'b0;
      step();
    end
    noise();
    uart_if.tx_done = 1'b1;
    step();
  endtask

  // One host command from IDLE back to IDLE. done_at: busy cycle with client done (0 or >TMO
  // means never). rst_at: busy cycle in which reset is applied (0 = never).
  task automatic txn(input logic [7:0] b, input int ack_dly, input int done_at, input int rst_at);
    int idx, c;
    bit tmo;
    idx = lookup(b);
    c = (idx >= 0) ? tbl_client[idx] : 0;
    noise();
    uart_if.rx_ready = 1'b1;
    uart_if.rx_data  = b;
    step();
    if (idx >= 0) begin
      e_client = c;
      e_mode   = tbl_mode[idx];
      e_txd    = b;
    end else begin
      e_txd  = NACK;
      e_wait = 0;
    end
    e_txs = 1;
    noise();
    step();
    e_txs = 0;
    e_txd = '0;
    wait_tx_done(ack_dly);
    if (idx < 0) begin
      set_idle();
      return;
    end
    e_grant = 2'(1 << c);
    e_wait  = 0;
    e_busy  = 1;
    tmo = 1;
    for (int k = 1; k <= TMO; k++) begin
      noise();
      done[c] = (k == done_at);
      if (k == rst_at) begin
        rst = 1'b1;
        step();
        rst = 1'b0;
        set_reset_exp();
        return;
      end
      step();
      if (k == done_at) begin
        tmo = 0;
        break;
      end
    end
    e_grant = '0; e_busy = 0; e_sr = 1; e_tmo = tmo;
    for (int j = 1; j < CLN; j++) begin
      noise();
      step();
      e_tmo = 0;
    end
    noise();
    step();
    e_sr = 0;
    e_tmo = 0;
    if (tmo) begin
      e_txs = 1;
      e_txd = TBYTE;
      noise();
      step();
      e_txs = 0;
      e_txd = '0;
      wait_tx_done($urandom_range(0, 3));
    end
    set_idle();
  endtask

  // Per-cycle compare against the model.
  initial forever begin
    @(negedge clk);
    if (chk_on) begin
      xd = e_busy ? cl_data[8*e_client +: 8] : e_txd;
      xs = e_busy ? cl_start[e_client] : e_txs;
      chk("grant", 32'(grant), 32'(e_grant));
      chk("soft_reset", 32'(soft_reset), 32'(e_sr));
      chk("tx_start", 32'(uart_if.tx_start), 32'(xs));
      chk("tx_data", 32'(uart_if.tx_data), 32'(xd));
      chk("mode", 32'(mode), 32'(e_mode));
      chk("active_client", 32'(active), 32'(e_client));
      chk("timeout", 32'(timeout), 32'(e_tmo));
      chk("c2_waiting", 32'(waiting), 32'(e_wait));
    end
  end

  initial forever begin
    @(negedge clk);
    if (grant != 0) begin
      g_run++;
      seen_grant |= grant;
    end else begin
      if (g_run != 0) last_g_len = g_run;
      g_run = 0;
    end
    if (soft_reset) begin
      sr_run++;
      saw_sr = 1;
    end else begin
      if (sr_run != 0) last_sr_len = sr_run;
      sr_run = 0;
    end
    if (timeout) begin
      n_tmo++;
      tmo_dist = last_g_len;
    end
    if (uart_if.tx_start && grant == 0) begin
      n_arb++;
      last_arb = uart_if.tx_data;
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail + 1);
    $fatal(1);
  end

  initial begin
    logic [7:0] b;
    g_run = 0; sr_run = 0;
    clr_mon();
    rst = 1'b1;
    uart_if.rx_ready = 0; uart_if.rx_data = '0; uart_if.tx_done = 0;
    done = '0; cl_data = '0; cl_start = '0;
    set_reset_exp();
    step();
    step();
    chk_on = 1'b1;
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_waiting", 32'(waiting), 32'h1);
    step();
    rst = 1'b0;
    idle(2);

    // 1C -> client 0, IMEM, two-cycle cleanup
    clr_mon();
    txn(8'h1C, 2, 3, 0);
    idle(1);
    chk("d1_ack_byte", 32'(last_arb), 32'h1C);
    chk("d1_grant", 32'(seen_grant), 32'h1);
    chk("d1_mode", 32'(mode), 32'h0);
    chk("d1_sr_len", 32'(last_sr_len), 32'd2);

    // DE -> client 1, step mode; client 0 done ignored
    clr_mon();
    txn(8'hDE, 1, 5, 0);
    idle(1);
    chk("d2_ack_byte", 32'(last_arb), 32'hDE);
    chk("d2_grant", 32'(seen_grant), 32'h2);
    chk("d2_mode", 32'(mode), 32'h0);
    chk("d2_client", 32'(active), 32'h1);

    // unknown byte -> NACK only
    clr_mon();
    txn(8'h42, 3, 0, 0);
    idle(1);
    chk("d3_nack_byte", 32'(last_arb), 32'h15);
    chk("d3_nbytes", 32'(n_arb), 32'd1);
    chk("d3_no_grant", 32'(seen_grant), 32'h0);
    chk("d3_no_sr", 32'(saw_sr), 32'h0);

    // CE with no done -> timeout after 16 busy cycles, then EE
    clr_mon();
    txn(8'hCE, 0, 0, 0);
    idle(1);
    chk("d4_tmo_pulses", 32'(n_tmo), 32'd1);
    chk("d4_tmo_dist", 32'(tmo_dist), 32'd16);
    chk("d4_report", 32'(last_arb), 32'hEE);
    chk("d4_sr_len", 32'(last_sr_len), 32'd2);
    chk("d4_mode", 32'(mode), 32'h1);

    // CE with done in the expiry cycle -> no timeout
    clr_mon();
    txn(8'hCE, 0, 16, 0);
    idle(1);
    chk("d5_no_tmo", 32'(n_tmo), 32'd0);
    chk("d5_busy_len", 32'(last_g_len), 32'd16);
    chk("d5_nbytes", 32'(n_arb), 32'd1);

    // reset during BUSY, then 1D accepted
    txn(8'h1D, 0, 0, 5);
    chk("d6_rst_grant", 32'(grant), 32'h0);
    chk("d6_rst_sr", 32'(soft_reset), 32'h0);
    chk("d6_rst_wait", 32'(waiting), 32'h1);
    clr_mon();
    txn(8'h1D, 1, 2, 0);
    idle(1);
    chk("d6_ack_byte", 32'(last_arb), 32'h1D);
    chk("d6_mode", 32'(mode), 32'h1);
    chk("d6_client", 32'(active), 32'h0);

    for (int t = 0; t < 80; t++) begin
      if ($urandom_range(0, 9) < 7) b = tbl_code[$urandom_range(0, 3)];
      else b = 8'($urandom);
      txn(b, $urandom_range(0, 4), $urandom_range(1, 20),
          ($urandom_range(0, 14) == 0) ? $urandom_range(1, 10) : 0);
      idle($urandom_range(0, 2));
    end
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
